// File: rtl/sys_mem_arb_pkg.sv
// Shared types and constants for the system-memory arbiter and its tag FIFO.
package sys_mem_arb_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam int SYS_MEM_HST_ACC_ID        = 0;
    localparam int SYS_MEM_ADV7513_CNTRLR_ID = 1;

    // Agent ID width: at least one bit even for tiny agent counts.
    function automatic int id_width(input int num_agents);
        int w;
        w = $clog2(num_agents);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sys_mem_tag_fifo.sv
// Synchronous FIFO of agent IDs; remembers who issued each outstanding read.
module sys_mem_tag_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         pop_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW:0]      count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o     = (count_q == (PW+1)'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign push_ok    = push_i && !full_o;
    assign pop_ok     = pop_i && !empty_o;
    assign pop_data_o = mem_q[rd_ptr_q];

    // Pointers wrap naturally; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_q + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
        end
    end

endmodule

// File: rtl/sys_mem_arb.sv
// Round-robin merge of per-agent system-memory requests onto one controller port,
// with tagged in-order read return.
module sys_mem_arb
    import sys_mem_arb_pkg::*;
#(
    parameter int NUM_AGENTS     = 2,
    parameter int SYS_MEM_DATA_W = 32,
    parameter int SYS_MEM_ADDR_W = 27,
    parameter int RD_TAG_DEPTH   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_AGENTS-1:0]     agt_wren,
    input  logic [NUM_AGENTS-1:0]     agt_rden,
    input  logic [SYS_MEM_ADDR_W-1:0] agt_addr [NUM_AGENTS],
    input  logic [SYS_MEM_DATA_W-1:0] agt_wdata [NUM_AGENTS],
    output logic [NUM_AGENTS-1:0]     agt_wait,
    output logic [NUM_AGENTS-1:0]     agt_rd_valid,
    output logic [SYS_MEM_DATA_W-1:0] agt_rdata [NUM_AGENTS],
    input  logic                      mem_wait,
    output logic                      mem_wren,
    output logic                      mem_rden,
    output logic [SYS_MEM_ADDR_W-1:0] mem_addr,
    output logic [SYS_MEM_DATA_W-1:0] mem_wdata,
    input  logic                      mem_rd_valid,
    input  logic [SYS_MEM_DATA_W-1:0] mem_rdata,
    output logic                      rd_underflow
);

    localparam int IDW = id_width(NUM_AGENTS);
    localparam int PW  = $clog2(RD_TAG_DEPTH);

    arb_state_e                state_q;
    logic [IDW-1:0]            grant_q;
    logic [IDW-1:0]            last_grant_q;
    logic                      mem_wren_q;
    logic                      mem_rden_q;
    logic [SYS_MEM_ADDR_W-1:0] mem_addr_q;
    logic [SYS_MEM_DATA_W-1:0] mem_wdata_q;
    logic [NUM_AGENTS-1:0]     rd_valid_q;
    logic [SYS_MEM_DATA_W-1:0] rdata_q [NUM_AGENTS];
    logic                      underflow_q;

    logic [NUM_AGENTS-1:0]     req;
    logic                      found;
    logic [IDW-1:0]            pick;
    logic [IDW-1:0]            cand;
    int                        idx;
    logic                      accept;
    logic                      tag_push;
    logic                      tag_pop;
    logic                      tag_full;
    logic                      tag_empty;
    logic [IDW-1:0]            tag_head;
    logic [PW:0]               tag_count;

    assign req      = agt_wren | (agt_rden & {NUM_AGENTS{~tag_full}});
    assign accept   = (state_q == BUSY) && !mem_wait;
    assign tag_push = accept && mem_rden_q;
    assign tag_pop  = mem_rd_valid && (tag_count != '0);

    // First requester found scanning upward from the agent after the last winner.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        idx   = 0;
        for (int k = 1; k <= NUM_AGENTS; k++) begin
            idx  = (int'(last_grant_q) + k) % NUM_AGENTS;
            cand = IDW'(idx);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB;
            grant_q      <= '0;
            last_grant_q <= IDW'(NUM_AGENTS - 1);
            mem_wren_q   <= 1'b0;
            mem_rden_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            case (state_q)
                ARB: begin
                    if (found) begin
                        grant_q      <= pick;
                        last_grant_q <= pick;
                        mem_wren_q   <= agt_wren[pick];
                        // A full tag FIFO must never see a forwarded read.
                        mem_rden_q   <= agt_rden[pick] & ~tag_full;
                        mem_addr_q   <= agt_addr[pick];
                        mem_wdata_q  <= agt_wdata[pick];
                        state_q      <= BUSY;
                    end
                end
                BUSY: begin
                    if (!mem_wait) begin
                        mem_wren_q <= 1'b0;
                        mem_rden_q <= 1'b0;
                        state_q    <= ARB;
                    end
                end
                default: state_q <= ARB;
            endcase
        end
    end

    always_comb begin
        agt_wait = '1;
        for (int i = 0; i < NUM_AGENTS; i++) begin
            agt_wait[i] = ~(accept && (grant_q == IDW'(i)));
        end
    end

    sys_mem_tag_fifo #(
        .WIDTH (IDW),
        .DEPTH (RD_TAG_DEPTH)
    ) u_tag_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (tag_push),
        .push_data_i (grant_q),
        .pop_i       (tag_pop),
        .pop_data_o  (tag_head),
        .full_o      (tag_full),
        .empty_o     (tag_empty),
        .count_o     (tag_count)
    );

    // Returned data is steered to the agent at the head of the tag FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q  <= '0;
            underflow_q <= 1'b0;
            for (int i = 0; i < NUM_AGENTS; i++) begin
                rdata_q[i] <= '0;
            end
        end else begin
            rd_valid_q <= '0;
            if (tag_pop) begin
                rd_valid_q[tag_head] <= 1'b1;
                rdata_q[tag_head]    <= mem_rdata;
            end else if (mem_rd_valid && tag_empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign mem_wren     = mem_wren_q;
    assign mem_rden     = mem_rden_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign agt_rd_valid = rd_valid_q;
    assign agt_rdata    = rdata_q;
    assign rd_underflow = underflow_q;

endmodule

// File: tb/tb_sys_mem_arb.sv
// Self-checking bench for sys_mem_arb: cycle vectors plus a tag/return scoreboard.
module tb_sys_mem_arb;
    import sys_mem_arb_pkg::*;

    localparam int NA = 2;
    localparam int DW = 32;
    localparam int AW = 27;

    typedef struct {
        logic [1:0]    wren;
        logic [1:0]    rden;
        logic          memWait;
        logic          memRdValid;
        logic [DW-1:0] memRdata;
        logic          expWren;
        logic          expRden;
        logic [AW-1:0] expAddr;
        logic [DW-1:0] expWdata;
        logic [1:0]    expWait;
    } vec_t;

    typedef struct {
        logic          agent;
        logic [DW-1:0] data;
    } ret_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NA-1:0] agtWren = '0;
    logic [NA-1:0] agtRden = '0;
    logic [AW-1:0] agtAddr [NA];
    logic [DW-1:0] agtWdata [NA];
    logic [NA-1:0] agtWait;
    logic [NA-1:0] agtRdValid;
    logic [DW-1:0] agtRdata [NA];
    logic          memWait = 1'b0;
    logic          memWren;
    logic          memRden;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] memWdata;
    logic          memRdValid = 1'b0;
    logic [DW-1:0] memRdata = '0;
    logic          rdUnderflow;

    int   assertCount = 0;
    int   failCount   = 0;
    logic expTags[$];
    ret_t sb[$];
    logic modelUnderflow = 1'b0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    sys_mem_arb #(
        .NUM_AGENTS     (NA),
        .SYS_MEM_DATA_W (DW),
        .SYS_MEM_ADDR_W (AW),
        .RD_TAG_DEPTH   (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .agt_wren     (agtWren),
        .agt_rden     (agtRden),
        .agt_addr     (agtAddr),
        .agt_wdata    (agtWdata),
        .agt_wait     (agtWait),
        .agt_rd_valid (agtRdValid),
        .agt_rdata    (agtRdata),
        .mem_wait     (memWait),
        .mem_wren     (memWren),
        .mem_rden     (memRden),
        .mem_addr     (memAddr),
        .mem_wdata    (memWdata),
        .mem_rd_valid (memRdValid),
        .mem_rdata    (memRdata),
        .rd_underflow (rdUnderflow)
    );

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] want);
        assertCount++;
        if (act !== want) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] wr, input logic [1:0] rd, input logic mw,
                                input logic rv, input logic [DW-1:0] rdat, input logic ew,
                                input logic er, input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                                input logic [1:0] ewt);
        vec_t v;
        v.wren = wr;       v.rden = rd;       v.memWait = mw;
        v.memRdValid = rv; v.memRdata = rdat; v.expWren = ew;
        v.expRden = er;    v.expAddr = ea;    v.expWdata = ed;
        v.expWait = ewt;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        agtWren    = v.wren;
        agtRden    = v.rden;
        memWait    = v.memWait;
        memRdValid = v.memRdValid;
        memRdata   = v.memRdata;
        #1;
    endtask

    task automatic checkOutput(input vec_t v);
        ret_t r;
        compare("agt_wait", 32'(agtWait), 32'(v.expWait));
        compare("mem_wren", 32'(memWren), 32'(v.expWren));
        compare("mem_rden", 32'(memRden), 32'(v.expRden));
        if (v.expWren || v.expRden) compare("mem_addr", 32'(memAddr), 32'(v.expAddr));
        if (v.expWren) compare("mem_wdata", memWdata, v.expWdata);
        if (sb.size() > 0) begin
            r = sb.pop_front();
            compare("agt_rd_valid", 32'(agtRdValid), 32'(2'b01 << r.agent));
            compare("agt_rdata", agtRdata[r.agent], r.data);
        end else begin
            compare("agt_rd_valid idle", 32'(agtRdValid), 32'd0);
        end
        compare("rd_underflow", 32'(rdUnderflow), 32'(modelUnderflow));
    endtask

    // Model order matters: a return pops before a same-cycle acceptance pushes.
    task automatic runCycle(input vec_t v);
        ret_t r;
        applyStimulus(v);
        checkOutput(v);
        if (v.memRdValid) begin
            if (expTags.size() > 0) begin
                r.agent = expTags.pop_front();
                r.data  = v.memRdata;
                sb.push_back(r);
            end else begin
                modelUnderflow = 1'b1;
            end
        end
        for (int i = 0; i < NA; i++) begin
            if (!v.expWait[i] && v.rden[i]) expTags.push_back(1'(i));
        end
    endtask

    task automatic cyc(input logic [1:0] wr, input logic [1:0] rd, input logic mw, input logic rv,
                       input logic [DW-1:0] rdat, input logic ew, input logic er,
                       input logic [AW-1:0] ea, input logic [DW-1:0] ed, input logic [1:0] ewt);
        runCycle(mk(wr, rd, mw, rv, rdat, ew, er, ea, ed, ewt));
    endtask

    task automatic doReset();
        @(negedge clk);
        rst        = 1'b1;
        agtWren    = '0;
        agtRden    = '0;
        memWait    = 1'b0;
        memRdValid = 1'b0;
        @(negedge clk);
        #1;
        compare("reset agt_wait", 32'(agtWait), 32'h3);
        compare("reset mem_wren", 32'(memWren), 32'd0);
        compare("reset mem_rden", 32'(memRden), 32'd0);
        compare("reset mem_addr", 32'(memAddr), 32'd0);
        compare("reset agt_rd_valid", 32'(agtRdValid), 32'd0);
        compare("reset agt_rdata0", agtRdata[0], 32'd0);
        compare("reset agt_rdata1", agtRdata[1], 32'd0);
        compare("reset rd_underflow", 32'(rdUnderflow), 32'd0);
        rst = 1'b0;
        expTags.delete();
        sb.delete();
        modelUnderflow = 1'b0;
    endtask

    initial begin
        agtAddr[0]  = '0; agtAddr[1]  = '0;
        agtWdata[0] = '0; agtWdata[1] = '0;
        doReset();

        // Contention: both agents read continuously, then four in-order returns.
        agtAddr[SYS_MEM_HST_ACC_ID]        = 27'h10;
        agtAddr[SYS_MEM_ADV7513_CNTRLR_ID] = 27'h20;
        for (int k = 0; k < 2; k++) begin
            tbl.push_back(mk(2'b00, 2'b11, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0,     '0, 2'b11));
            tbl.push_back(mk(2'b00, 2'b11, 1'b0, 1'b0, '0, 1'b0, 1'b1, 27'h10, '0, 2'b10));
            tbl.push_back(mk(2'b00, 2'b11, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0,     '0, 2'b11));
            tbl.push_back(mk(2'b00, 2'b11, 1'b0, 1'b0, '0, 1'b0, 1'b1, 27'h20, '0, 2'b01));
        end
        tbl.push_back(mk(2'b00, 2'b00, 1'b0, 1'b1, 32'hA, 1'b0, 1'b0, '0, '0, 2'b11));
        tbl.push_back(mk(2'b00, 2'b00, 1'b0, 1'b1, 32'hB, 1'b0, 1'b0, '0, '0, 2'b11));
        tbl.push_back(mk(2'b00, 2'b00, 1'b0, 1'b1, 32'hC, 1'b0, 1'b0, '0, '0, 2'b11));
        tbl.push_back(mk(2'b00, 2'b00, 1'b0, 1'b1, 32'hD, 1'b0, 1'b0, '0, '0, 2'b11));
        tbl.push_back(mk(2'b00, 2'b00, 1'b0, 1'b0, '0,    1'b0, 1'b0, '0, '0, 2'b11));
        for (int i = 0; i < tbl.size(); i++) runCycle(tbl[i]);

        // Single write from the host agent.
        agtAddr[0]  = 27'h100;
        agtWdata[0] = 32'hCAFEF00D;
        cyc(2'b01, 2'b00, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0,      '0,           2'b11);
        cyc(2'b01, 2'b00, 1'b0, 1'b0, '0, 1'b1, 1'b0, 27'h100, 32'hCAFEF00D, 2'b10);
        cyc(2'b00, 2'b00, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0,      '0,           2'b11);

        // Stall: five held BUSY cycles, accepted on the sixth.
        doReset();
        agtAddr[0]  = 27'h40;
        agtWdata[0] = 32'h12345678;
        cyc(2'b01, 2'b00, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, 2'b11);
        for (int k = 0; k < 5; k++)
            cyc(2'b01, 2'b00, 1'b1, 1'b0, '0, 1'b1, 1'b0, 27'h40, 32'h12345678, 2'b11);
        cyc(2'b01, 2'b00, 1'b0, 1'b0, '0, 1'b1, 1'b0, 27'h40, 32'h12345678, 2'b10);
        cyc(2'b00, 2'b00, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 2'b11);

        // Tag full: eight reads fill the FIFO, a write still wins, one return frees a slot.
        doReset();
        agtAddr[0]  = 27'h80;
        agtAddr[1]  = 27'h300;
        agtWdata[1] = 32'hDEAD0001;
        for (int k = 0; k < 8; k++) begin
            cyc(2'b00, 2'b01, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0,     '0, 2'b11);
            cyc(2'b00, 2'b01, 1'b0, 1'b0, '0, 1'b0, 1'b1, 27'h80, '0, 2'b10);
        end
        cyc(2'b10, 2'b01, 1'b0, 1'b0, '0,     1'b0, 1'b0, '0,      '0,           2'b11);
        cyc(2'b10, 2'b01, 1'b0, 1'b0, '0,     1'b1, 1'b0, 27'h300, 32'hDEAD0001, 2'b01);
        cyc(2'b00, 2'b01, 1'b0, 1'b0, '0,     1'b0, 1'b0, '0,      '0,           2'b11);
        cyc(2'b00, 2'b01, 1'b0, 1'b1, 32'h55, 1'b0, 1'b0, '0,      '0,           2'b11);
        cyc(2'b00, 2'b01, 1'b0, 1'b0, '0,     1'b0, 1'b0, '0,      '0,           2'b11);
        cyc(2'b00, 2'b01, 1'b0, 1'b0, '0,     1'b0, 1'b1, 27'h80,  '0,           2'b10);
        cyc(2'b00, 2'b00, 1'b0, 1'b0, '0,     1'b0, 1'b0, '0,      '0,           2'b11);

        // Push/pop overlap, then a return with nothing outstanding.
        doReset();
        agtAddr[0] = 27'h50;
        agtAddr[1] = 27'h60;
        cyc(2'b00, 2'b01, 1'b0, 1'b0, '0,     1'b0, 1'b0, '0,     '0, 2'b11);
        cyc(2'b00, 2'b01, 1'b0, 1'b0, '0,     1'b0, 1'b1, 27'h50, '0, 2'b10);
        cyc(2'b00, 2'b10, 1'b0, 1'b0, '0,     1'b0, 1'b0, '0,     '0, 2'b11);
        cyc(2'b00, 2'b10, 1'b0, 1'b1, 32'h11, 1'b0, 1'b1, 27'h60, '0, 2'b01);
        cyc(2'b00, 2'b00, 1'b0, 1'b1, 32'h22, 1'b0, 1'b0, '0,     '0, 2'b11);
        cyc(2'b00, 2'b00, 1'b0, 1'b1, 32'hEE, 1'b0, 1'b0, '0,     '0, 2'b11);
        cyc(2'b00, 2'b00, 1'b0, 1'b0, '0,     1'b0, 1'b0, '0,     '0, 2'b11);

        // Reset while BUSY with a stalled write and a sticky underflow pending.
        agtAddr[0]  = 27'h70;
        agtWdata[0] = 32'h0BADBEEF;
        cyc(2'b01, 2'b00, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0,     '0,           2'b11);
        cyc(2'b01, 2'b00, 1'b1, 1'b0, '0, 1'b1, 1'b0, 27'h70, 32'h0BADBEEF, 2'b11);
        doReset();
        cyc(2'b00, 2'b00, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0,     '0,           2'b11);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
